// File: rtl/rvj1_mem_arbiter_pkg.sv
// Shared types and constants for the rvj1 memory-port arbiter.
package rvj1_mem_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam logic [3:0]  BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_IFU,
    OWNER_LSU
  } mem_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_IFU,
    ARB_WAIT_LSU
  } arb_fsm_e;

endpackage

// File: rtl/rvj1_arb_picker.sv
// Owner selection for the shared memory port: request lock under a stalled
// grant and an LSU streak limit that guarantees fetch forward progress.
module rvj1_arb_picker
  import rvj1_mem_arbiter_pkg::*;
#(
  parameter  int unsigned LSU_MAX_CONSEC = 4,
  localparam int unsigned STREAK_W       = $clog2(LSU_MAX_CONSEC + 1)
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       window_i,
  input  logic       ifu_req_i,
  input  logic       lsu_req_i,
  input  logic       mem_gnt_i,
  output mem_owner_e sel_o,
  output logic       issue_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LSU_MAX_CONSEC);

  mem_owner_e          lock_q, lock_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  mem_owner_e          sel;
  logic                sel_req;
  logic                issue;
  logic                grant;

  // Pick the owner: a stalled request keeps its slot, otherwise LSU wins until its streak is exhausted.
  always_comb begin
    sel     = OWNER_NONE;
    sel_req = 1'b0;
    if (lock_q != OWNER_NONE) begin
      sel = lock_q;
    end else if (lsu_req_i && !(ifu_req_i && streak_q == STREAK_MAX)) begin
      sel = OWNER_LSU;
    end else if (ifu_req_i) begin
      sel = OWNER_IFU;
    end
    case (sel)
      OWNER_IFU: sel_req = ifu_req_i;
      OWNER_LSU: sel_req = lsu_req_i;
      default:   sel_req = 1'b0;
    endcase
    issue = window_i && sel_req;
    grant = issue && mem_gnt_i;
  end

  // Lock and streak bookkeeping for the next cycle.
  always_comb begin
    lock_d   = lock_q;
    streak_d = streak_q;
    if (issue && !mem_gnt_i) begin
      lock_d = sel;
    end else if (grant) begin
      lock_d = OWNER_NONE;
    end
    if (!ifu_req_i) begin
      streak_d = '0;
    end else if (grant && sel == OWNER_IFU) begin
      streak_d = '0;
    end else if (grant && sel == OWNER_LSU && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Lock and streak registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_q   <= OWNER_NONE;
      streak_q <= '0;
    end else begin
      lock_q   <= lock_d;
      streak_q <= streak_d;
    end
  end

  assign sel_o   = sel;
  assign issue_o = issue;

endmodule

// File: rtl/rvj1_mem_arbiter.sv
// Shares the core memory port between fetch and load/store, one OBI-style
// transaction outstanding, with response routing and flush-drop of fetches.
module rvj1_mem_arbiter
  import rvj1_mem_arbiter_pkg::*;
#(
  parameter int unsigned LSU_MAX_CONSEC = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            ifu_req_i,
  input  logic [XLEN-1:0] ifu_addr_i,
  output logic            ifu_gnt_o,
  output logic            ifu_rvalid_o,
  output logic [XLEN-1:0] ifu_rdata_o,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [3:0]      lsu_be_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_gnt_o,
  output logic            lsu_rvalid_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  arb_fsm_e   state_q, state_d;
  logic       drop_q, drop_d;
  logic       window;
  logic       issue;
  logic       granted;
  mem_owner_e sel;

  rvj1_arb_picker #(
    .LSU_MAX_CONSEC(LSU_MAX_CONSEC)
  ) u_picker (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .window_i (window),
    .ifu_req_i(ifu_req_i),
    .lsu_req_i(lsu_req_i),
    .mem_gnt_i(mem_gnt_i),
    .sel_o    (sel),
    .issue_o  (issue)
  );

  // Issue window, memory request muxing, grants, next state and response routing.
  always_comb begin
    window       = (state_q == ARB_IDLE) || mem_rvalid_i;
    mem_req_o    = rstn_i && issue;
    granted      = mem_req_o && mem_gnt_i;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (mem_req_o) begin
      if (sel == OWNER_LSU) begin
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
      end else begin
        mem_be_o    = BE_ALL;
        mem_addr_o  = ifu_addr_i;
      end
    end
    ifu_gnt_o = granted && (sel == OWNER_IFU);
    lsu_gnt_o = granted && (sel == OWNER_LSU);

    state_d = state_q;
    if (state_q != ARB_IDLE && mem_rvalid_i) begin
      state_d = ARB_IDLE;
    end
    if (granted) begin
      state_d = (sel == OWNER_LSU) ? ARB_WAIT_LSU : ARB_WAIT_IFU;
    end

    // A response arriving clears drop, so a fetch granted in the same cycle starts clean.
    drop_d = drop_q;
    if (state_q == ARB_WAIT_IFU) begin
      if (mem_rvalid_i) begin
        drop_d = 1'b0;
      end else if (flush_i) begin
        drop_d = 1'b1;
      end
    end

    ifu_rvalid_o = (state_q == ARB_WAIT_IFU) && mem_rvalid_i && !(drop_q || flush_i);
    lsu_rvalid_o = (state_q == ARB_WAIT_LSU) && mem_rvalid_i;
    ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
    lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
  end

  // FSM state and flush-drop flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // A response with nothing outstanding indicates a broken memory model.
  a_no_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(state_q == ARB_IDLE && mem_rvalid_i));

endmodule

// File: tb/tb_rvj1_mem_arbiter.sv
// Self-checking bench for rvj1_mem_arbiter: scenario tasks plus a response scoreboard.
module tb_rvj1_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o;
  logic        ifu_rvalid_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];

  rvj1_mem_arbiter #(.LSU_MAX_CONSEC(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Response monitor: inputs change on the falling edge, outputs are sampled 2 time units later.
  always @(negedge clk_i) begin
    #2;
    if (rstn_i) begin
      if (ifu_rvalid_o) begin
        tests_run++;
        if (ifu_q.size() == 0) begin
          tests_failed++;
          $display("FAIL ifu_rsp_unexpected: got rvalid data %h, required no response", ifu_rdata_o);
        end else begin
          logic [31:0] e;
          e = ifu_q.pop_front();
          if (ifu_rdata_o !== e) begin
            tests_failed++;
            $display("FAIL ifu_rsp_data: got %h, required %h", ifu_rdata_o, e);
          end
        end
      end else begin
        tests_run++;
        if (ifu_rdata_o !== 32'h0) begin
          tests_failed++;
          $display("FAIL ifu_rdata_idle: got %h, required 0", ifu_rdata_o);
        end
      end
      if (lsu_rvalid_o) begin
        tests_run++;
        if (lsu_q.size() == 0) begin
          tests_failed++;
          $display("FAIL lsu_rsp_unexpected: got rvalid data %h, required no response", lsu_rdata_o);
        end else begin
          logic [31:0] e;
          e = lsu_q.pop_front();
          if (lsu_rdata_o !== e) begin
            tests_failed++;
            $display("FAIL lsu_rsp_data: got %h, required %h", lsu_rdata_o, e);
          end
        end
      end else begin
        tests_run++;
        if (lsu_rdata_o !== 32'h0) begin
          tests_failed++;
          $display("FAIL lsu_rdata_idle: got %h, required 0", lsu_rdata_o);
        end
      end
    end
  end

  task automatic idle_inputs();
    flush_i = 0; ifu_req_i = 0; ifu_addr_i = 0;
    lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic test_reset();
    rstn_i = 0;
    idle_inputs();
    @(negedge clk_i);
    ifu_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1; ifu_addr_i = 32'h1234;
    #1;
    tests_run++;
    if ({mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 00000",
               {mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o});
    end
    tests_run++;
    if ({mem_addr_o, mem_be_o, mem_we_o} !== 37'h0) begin
      tests_failed++;
      $display("FAIL reset_mem_fields: got addr %h be %h we %b, required all 0", mem_addr_o, mem_be_o, mem_we_o);
    end
    @(negedge clk_i);
    idle_inputs();
    rstn_i = 1;
  endtask

  task automatic test_ifu_stream();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      ifu_req_i    = (i < 3);
      ifu_addr_i   = 32'h8000_0000 + 32'(4 * i);
      mem_gnt_i    = 1;
      mem_rvalid_i = (i > 0);
      mem_rdata_i  = 32'hC0DE_0000 + 32'(i - 1);
      if (i > 0) ifu_q.push_back(32'hC0DE_0000 + 32'(i - 1));
      #1;
      tests_run++;
      if (ifu_gnt_o !== (i < 3) || lsu_gnt_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL ifu_stream_gnt[%0d]: got ifu %b lsu %b, required ifu %b lsu 0", i, ifu_gnt_o, lsu_gnt_o, i < 3);
      end
      if (i < 3) begin
        tests_run++;
        if (mem_addr_o !== 32'h8000_0000 + 32'(4 * i) || mem_we_o !== 1'b0 ||
            mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
          tests_failed++;
          $display("FAIL ifu_stream_fields[%0d]: got addr %h we %b be %h wdata %h, required addr %h we 0 be f wdata 0",
                   i, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, 32'h8000_0000 + 32'(4 * i));
        end
      end
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_lsu_streak();
    int   streak = 0;
    logic prev_lsu = 0;
    logic exp_lsu;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      ifu_req_i    = (k < 10);
      ifu_addr_i   = 32'h1000 + 32'(4 * k);
      lsu_req_i    = (k < 10);
      lsu_we_i     = 0;
      lsu_be_i     = 4'hF;
      lsu_addr_i   = 32'h2000 + 32'(4 * k);
      mem_gnt_i    = 1;
      mem_rvalid_i = (k > 0);
      mem_rdata_i  = 32'hA000 + 32'(k);
      if (k > 0) begin
        if (prev_lsu) lsu_q.push_back(32'hA000 + 32'(k));
        else          ifu_q.push_back(32'hA000 + 32'(k));
      end
      #1;
      if (k < 10) begin
        exp_lsu = (streak != 4);
        tests_run++;
        if (lsu_gnt_o !== exp_lsu || ifu_gnt_o !== !exp_lsu) begin
          tests_failed++;
          $display("FAIL streak_gnt[%0d]: got lsu %b ifu %b, required lsu %b ifu %b",
                   k, lsu_gnt_o, ifu_gnt_o, exp_lsu, !exp_lsu);
        end
        tests_run++;
        if (mem_addr_o !== (exp_lsu ? 32'h2000 + 32'(4 * k) : 32'h1000 + 32'(4 * k))) begin
          tests_failed++;
          $display("FAIL streak_addr[%0d]: got %h, required %h", k, mem_addr_o,
                   exp_lsu ? 32'h2000 + 32'(4 * k) : 32'h1000 + 32'(4 * k));
        end
        streak   = exp_lsu ? streak + 1 : 0;
        prev_lsu = exp_lsu;
      end else begin
        tests_run++;
        if (mem_req_o !== 1'b0) begin
          tests_failed++;
          $display("FAIL streak_drain_req: got %b, required 0", mem_req_o);
        end
      end
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_stalled_store();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011;
      lsu_addr_i = 32'h100; lsu_wdata_i = 32'hDEAD_BEEF;
      ifu_req_i = (c > 0); ifu_addr_i = 32'h900;
      mem_gnt_i = (c == 3);
      #1;
      tests_run++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_be_o !== 4'b0011 ||
          mem_addr_o !== 32'h100 || mem_wdata_o !== 32'hDEAD_BEEF) begin
        tests_failed++;
        $display("FAIL stall_fields[%0d]: got req %b we %b be %b addr %h wdata %h, required 1 1 0011 100 deadbeef",
                 c, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
      end
      tests_run++;
      if (ifu_gnt_o !== 1'b0 || lsu_gnt_o !== (c == 3)) begin
        tests_failed++;
        $display("FAIL stall_gnt[%0d]: got ifu %b lsu %b, required ifu 0 lsu %b", c, ifu_gnt_o, lsu_gnt_o, c == 3);
      end
    end
    @(negedge clk_i);
    lsu_req_i = 0; lsu_we_i = 0;
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    lsu_q.push_back(32'h0);
    #1;
    tests_run++;
    if (ifu_gnt_o !== 1'b1 || mem_addr_o !== 32'h900) begin
      tests_failed++;
      $display("FAIL stall_ifu_after: got gnt %b addr %h, required 1 900", ifu_gnt_o, mem_addr_o);
    end
    @(negedge clk_i);
    ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0901;
    ifu_q.push_back(32'h0000_0901);
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    ifu_req_i = 1; ifu_addr_i = 32'h200; mem_gnt_i = 1;
    #1;
    tests_run++;
    if (ifu_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_gnt: got %b, required 1", ifu_gnt_o);
    end
    @(negedge clk_i);
    ifu_req_i = 0; flush_i = 1;
    @(negedge clk_i);
    flush_i = 0;
    @(negedge clk_i);
    mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    #1;
    tests_run++;
    if (ifu_rvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: got rvalid %b, required 0", ifu_rvalid_o);
    end
    @(negedge clk_i);
    mem_rvalid_i = 0; ifu_req_i = 1; ifu_addr_i = 32'h300;
    #1;
    tests_run++;
    if (ifu_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_refetch_gnt: got %b, required 1", ifu_gnt_o);
    end
    @(negedge clk_i);
    flush_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h17; ifu_addr_i = 32'h304;
    #1;
    tests_run++;
    if (ifu_rvalid_o !== 1'b0 || ifu_gnt_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_same_cycle: got rvalid %b gnt %b, required 0 1", ifu_rvalid_o, ifu_gnt_o);
    end
    @(negedge clk_i);
    flush_i = 0; ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h19;
    ifu_q.push_back(32'h19);
    #1;
    tests_run++;
    if (ifu_rvalid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_next_delivered: got rvalid %b, required 1", ifu_rvalid_o);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    lsu_req_i = 1; lsu_addr_i = 32'h400; lsu_be_i = 4'hF; mem_gnt_i = 1;
    @(negedge clk_i);
    lsu_req_i = 0; ifu_req_i = 1; ifu_addr_i = 32'h500;
    mem_rvalid_i = 1; mem_rdata_i = 32'h55AA;
    lsu_q.push_back(32'h55AA);
    #1;
    tests_run++;
    if (lsu_rvalid_o !== 1'b1 || ifu_gnt_o !== 1'b1 || ifu_rvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_overlap: got lsu_rvalid %b ifu_gnt %b ifu_rvalid %b, required 1 1 0",
               lsu_rvalid_o, ifu_gnt_o, ifu_rvalid_o);
    end
    @(negedge clk_i);
    ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    ifu_q.push_back(32'h77);
    #1;
    tests_run++;
    if (ifu_rvalid_o !== 1'b1 || lsu_rvalid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_wait_ifu: got ifu_rvalid %b lsu_rvalid %b, required 1 0", ifu_rvalid_o, lsu_rvalid_o);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    lsu_req_i = 1; lsu_addr_i = 32'h600; lsu_be_i = 4'hF; mem_gnt_i = 1;
    @(negedge clk_i);
    lsu_req_i = 0; ifu_req_i = 1; ifu_addr_i = 32'h700;
    #1;
    tests_run++;
    if (mem_req_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_pending_req: got %b, required 0", mem_req_o);
    end
    #2;
    rstn_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
    #1;
    tests_run++;
    if ({mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o} !== 5'b0 ||
        lsu_rdata_o !== 32'h0 || mem_addr_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_outputs: got ctrl %b lsu_rdata %h addr %h, required 0",
               {mem_req_o, ifu_gnt_o, lsu_gnt_o, ifu_rvalid_o, lsu_rvalid_o}, lsu_rdata_o, mem_addr_o);
    end
    mem_rvalid_i = 0;
    @(negedge clk_i);
    rstn_i = 1;
    #1;
    tests_run++;
    if (ifu_gnt_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h700) begin
      tests_failed++;
      $display("FAIL areset_first_issue: got gnt %b req %b addr %h, required 1 1 700", ifu_gnt_o, mem_req_o, mem_addr_o);
    end
    @(negedge clk_i);
    ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h88;
    ifu_q.push_back(32'h88);
    @(negedge clk_i);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ifu_stream();
    test_lsu_streak();
    test_stalled_store();
    test_flush();
    test_back_to_back();
    test_async_reset();
    @(negedge clk_i);
    #3;
    tests_run++;
    if (ifu_q.size() != 0 || lsu_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got ifu %0d lsu %0d pending, required 0 0", ifu_q.size(), lsu_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
